// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared FSM encodings, default geometry and address-split width helpers
package inst_cache_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_FILL = 2'd1,
        IC_DONE = 2'd2
    } ic_state_t;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int ic_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int ic_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int ic_tag_w(input int lines, input int line_words);
        return 30 - ic_off_w(line_words) - ic_idx_w(lines);
    endfunction

endpackage

// File: rtl/inst_cache_ram.sv
// inst_cache_ram: data and tag arrays, one synchronous write port, combinational read port
module inst_cache_ram
    import inst_cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    localparam int OFF_W     = ic_off_w(LINE_WORDS),
    localparam int IDX_W     = ic_idx_w(LINES),
    localparam int TAG_W     = ic_tag_w(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             i_dwe,
    input  logic             i_twe,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [OFF_W-1:0] i_woff,
    input  logic [31:0]      i_wdata,
    input  logic [TAG_W-1:0] i_wtag,
    input  logic [IDX_W-1:0] i_ridx,
    input  logic [OFF_W-1:0] i_roff,
    output logic [31:0]      o_rdata,
    output logic [TAG_W-1:0] o_rtag
);

    logic [31:0]      r_data [LINES*LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];

    always_ff @(posedge clk) begin
        if (i_dwe) r_data[{i_widx, i_woff}] <= i_wdata;
        if (i_twe) r_tag[i_widx] <= i_wtag;
    end

    assign o_rdata = r_data[{i_ridx, i_roff}];
    assign o_rtag  = r_tag[i_ridx];

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with word-at-a-time line fill
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        cpu_rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFF_W = ic_off_w(LINE_WORDS);
    localparam int IDX_W = ic_idx_w(LINES);
    localparam int TAG_W = ic_tag_w(LINES, LINE_WORDS);

    ic_state_t        r_state, w_next;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_fill_tag;
    logic [IDX_W-1:0] r_fill_idx;
    logic [OFF_W-1:0] r_cnt;
    logic             r_kill;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;

    logic [OFF_W-1:0] w_off, w_cnt_nxt;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag, w_rtag;
    logic [31:0]      w_rdata;
    logic             w_hit, w_start, w_dwe, w_twe, w_last, w_unused;

    assign w_off     = inst_addr[OFF_W+1:2];
    assign w_idx     = inst_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign w_tag     = inst_addr[31:IDX_W+OFF_W+2];
    assign w_unused  = &{1'b0, inst_addr[1:0]};
    assign w_last    = &r_cnt;
    assign w_cnt_nxt = r_cnt + OFF_W'(1);

    inst_cache_ram #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_ram (
        .clk     (clk),
        .i_dwe   (w_dwe),
        .i_twe   (w_twe),
        .i_widx  (r_fill_idx),
        .i_woff  (r_cnt),
        .i_wdata (mem_rdata),
        .i_wtag  (r_fill_tag),
        .i_ridx  (w_idx),
        .i_roff  (w_off),
        .o_rdata (w_rdata),
        .o_rtag  (w_rtag)
    );

    assign w_hit      = inst_ren & r_valid[w_idx] & (w_rtag == w_tag) & (r_state == IC_IDLE);
    assign inst_data  = w_hit ? w_rdata : 32'd0;
    assign inst_stall = inst_ren & ~w_hit;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

    always_comb begin
        w_start = (r_state == IC_IDLE) & inst_ren & ~w_hit & ~flush;
        w_dwe   = (r_state == IC_FILL) & mem_ack & ~cpu_rst;
        w_twe   = (r_state == IC_DONE) & ~cpu_rst;
        w_next  = w_start ? IC_FILL :
                  (r_state == IC_FILL) ? ((mem_ack & w_last) ? IC_DONE : IC_FILL) : IC_IDLE;
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            r_state    <= IC_IDLE;
            r_valid    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
            r_kill     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (flush) r_valid <= '0;
            else if (r_state == IC_DONE && !r_kill) r_valid[r_fill_idx] <= 1'b1;
            // a flush seen anywhere in the fill must keep the line from being validated
            if (w_start) r_kill <= 1'b0;
            else if (flush) r_kill <= 1'b1;
            if (w_start) begin
                r_fill_tag <= w_tag;
                r_fill_idx <= w_idx;
                r_cnt      <= '0;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
            end else if (w_dwe) begin
                r_cnt      <= w_cnt_nxt;
                r_mem_addr <= {r_fill_tag, r_fill_idx, w_cnt_nxt, 2'b00};
                if (w_last) r_mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized and directed checks of inst_cache against a line-level reference model
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        inst_ren = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] inst_data, mem_addr, mem_rdata;
    logic        inst_stall, mem_req, mem_ack;

    int total = 0;
    int bad = 0;
    int ack_mode = 0;
    int cyc = 0;
    logic rnd = 1'b0;

    always #5 clk = ~clk;

    inst_cache dut (
        .clk        (clk),
        .cpu_rst    (cpu_rst),
        .inst_ren   (inst_ren),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_stall (inst_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd <= ($urandom_range(0, 1) == 1);
    end

    // memory content is a fixed function of the word address; mode 1 also acks with no request
    assign mem_rdata = 32'h1000_0000 + mem_addr;
    assign mem_ack   = (ack_mode == 0) ? mem_req :
                       (ack_mode == 2) ? (mem_req && (cyc % 3 == 0)) : rnd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        m_known = 1'b0;
    logic        m_valid [16];
    logic [23:0] m_tag [16];
    logic        m_busy = 1'b0, m_flushed = 1'b0, m_zero = 1'b0;
    int          m_left = 0;
    logic [31:0] m_base = 32'd0;

    always @(negedge clk) begin : model
        logic [3:0]  ix;
        logic [23:0] tg;
        logic        hit;
        ix  = inst_addr[7:4];
        tg  = inst_addr[31:8];
        hit = inst_ren && !m_busy && m_valid[ix] && m_tag[ix] == tg;
        if (m_known) begin
            chk("stall", inst_stall, inst_ren && !hit);
            chk("data", inst_data, hit ? 32'h1000_0000 + {inst_addr[31:2], 2'b00} : 32'd0);
            chk("req", mem_req, m_busy && m_left > 0);
            if (m_busy && m_left > 0) chk("maddr", mem_addr, m_base + 32'(4 * (4 - m_left)));
            else if (m_zero) chk("maddr_rst", mem_addr, 32'd0);
        end
        if (cpu_rst) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_zero  = 1'b1;
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (m_known) begin
            if (m_busy) begin
                if (m_left > 0) begin
                    if (mem_ack) m_left--;
                end else begin
                    if (!m_flushed && !flush) begin
                        m_valid[m_base[7:4]] = 1'b1;
                        m_tag[m_base[7:4]]   = m_base[31:8];
                    end
                    m_busy = 1'b0;
                end
                if (flush) m_flushed = 1'b1;
            end else if (inst_ren && !hit && !flush) begin
                m_busy    = 1'b1;
                m_left    = 4;
                m_base    = {inst_addr[31:4], 4'b0000};
                m_flushed = 1'b0;
                m_zero    = 1'b0;
            end
            if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end
    end

    task automatic run_miss(output int stalls, output logic [31:0] first, output logic [31:0] last,
                            output int nacks);
        stalls = 0;
        nacks  = 0;
        first  = 32'hffff_ffff;
        last   = 32'hffff_ffff;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!inst_stall) break;
            stalls++;
            if (mem_req && mem_ack) begin
                if (nacks == 0) first = mem_addr;
                last = mem_addr;
                nacks++;
            end
            step();
        end
    endtask

    initial begin : directed
        int          st, na, n;
        logic [31:0] fa, la;
        logic [31:0] hits [3];
        hits[0] = 32'h0;
        hits[1] = 32'h4;
        hits[2] = 32'hC;
        cpu_rst   = 1'b1;
        inst_ren  = 1'b1;
        inst_addr = 32'h8;
        step();
        @(negedge clk);
        chk("rst_stall", inst_stall, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        step();
        cpu_rst = 1'b0;
        run_miss(st, fa, la, na);
        chk("cold_stalls", st, 6);
        chk("cold_acks", na, 4);
        chk("cold_first", fa, 32'h0);
        chk("cold_last", la, 32'hC);
        chk("cold_data", inst_data, 32'h1000_0008);
        for (int i = 0; i < 3; i++) begin
            step();
            inst_addr = hits[i];
            @(negedge clk);
            chk("hit_stall", inst_stall, 0);
            chk("hit_data", inst_data, 32'h1000_0000 + hits[i]);
            chk("hit_req", mem_req, 0);
        end
        step();
        inst_addr = 32'h100;
        run_miss(st, fa, la, na);
        chk("conf_stalls", st, 6);
        chk("conf_first", fa, 32'h100);
        chk("conf_last", la, 32'h10C);
        step();
        inst_addr = 32'h0;
        @(negedge clk);
        chk("conf_remiss", inst_stall, 1);
        run_miss(st, fa, la, na);
        step();
        inst_addr = 32'h200;
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) n++;
            if (n < 2) step();
        end
        chk("midrst_acks", n, 2);
        step();
        cpu_rst = 1'b1;
        step();
        cpu_rst   = 1'b0;
        inst_addr = 32'h0;
        @(negedge clk);
        chk("midrst_req", mem_req, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_miss", inst_stall, 1);
        run_miss(st, fa, la, na);
        ack_mode = 2;
        step();
        inst_addr = 32'h20;
        repeat (4) step();
        inst_addr = 32'h40;
        repeat (40) step();
        ack_mode = 0;
        inst_addr = 32'h60;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) ack_mode = $urandom_range(0, 2);
            cpu_rst  = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            inst_ren = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                inst_addr = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
            step();
        end
        cpu_rst  = 1'b0;
        flush    = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's instruction fetch port (inst_ren / inst_addr / inst_data) and a slower word-wide memory with a req/ack handshake.
- Hits return data combinationally in the same cycle, matching the existing fetch timing.
- Misses raise inst_stall while a line fill runs one word at a time. The fetch stage holds PC and suppresses register writes while stalled.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  input  1  main clock, rising-edge.
- cpu_rst  input  1  synchronous active-high reset.
- inst_ren  input  1  fetch request this cycle.
- inst_addr  input  32  byte address of the instruction; bits [1:0] are ignored.
- inst_data  output  32  instruction word; valid when inst_ren=1 and inst_stall=0; otherwise 0.
- inst_stall  output  1  high while the requested word is not available.
- flush  input  1  invalidate all lines.
- mem_req  output  1  memory read request (registered).
- mem_addr  output  32  word-aligned memory address (registered).
- mem_rdata  input  32  memory read data; valid in the cycle mem_ack=1.
- mem_ack  input  1  memory has accepted and completed the current word.

Behaviour:
- Interface: one clock, clk. Reset cpu_rst is synchronous and active-high.
- Address split:
  - OFF_W = log2(LINE_WORDS), IDX_W = log2(LINES).
  - word offset = inst_addr[OFF_W+1:2].
  - index = inst_addr[IDX_W+OFF_W+1:OFF_W+2].
  - tag = remaining upper bits.
- Storage: data array LINES×LINE_WORDS×32, tag array, one valid bit per line.
- Hit (combinational): hit = inst_ren & valid[index] & (tag_arr[index]==tag) & (state==IDLE).
  - inst_data = data[index][offset] when hit, else 0.
  - inst_stall = inst_ren & ~hit.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - On inst_ren & ~hit & ~flush: latch the tag and index into the fill registers, clear the word counter.
  - Drive mem_req=1 and mem_addr = {tag, index, 0, 2'b00} at the next edge, then go to FILL.
- FILL:
  - mem_req stays 1. mem_addr = {fill_tag, fill_index, cnt, 2'b00} and is held stable until mem_ack.
  - On mem_ack: write mem_rdata into data[fill_index][cnt] and increment cnt. mem_addr advances at the same edge.
  - On the ack for cnt = LINE_WORDS-1: mem_req goes to 0 and the FSM goes to DONE.
- DONE: write tag_arr[fill_index] = fill_tag and set valid=1 (unless flush), then go to IDLE. The next-cycle lookup hits.
- Miss latency: with acks in consecutive cycles, a miss seen at edge 0 returns hit data LINE_WORDS+2 cycles later (6 cycles for the default).
- inst_addr or inst_ren changing during FILL: no effect. The latched fill runs to completion, and IDLE then re-evaluates the current request; a mismatch is a new miss.
- flush:
  - Clears all valid bits at the edge; it has priority over the DONE validation in the same cycle.
  - During FILL, the fill continues (memory words cannot be aborted) but the line is not validated.
  - While flush=1 in IDLE, no new fill starts and inst_stall follows the hit logic (always a miss).
- Reset, including mid-fill: at the edge, state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, cnt=0. The tag and data arrays are not reset.
- The inst_data / inst_stall combinational equations hold during reset and give inst_stall = inst_ren.
- mem_ack while mem_req=0 is ignored.
- The cache never writes memory. Stores bypass it; self-modifying code requires flush.

Decomposition:
- Shared header (alongside the existing defines): FSM state encodings IC_IDLE=2'd0, IC_FILL=2'd1, IC_DONE=2'd2, and derived OFF_W / IDX_W / TAG_W localparam formulas.
- One natural sub-module: inst_cache_ram. It holds the data/tag arrays with one synchronous write port and a combinational read port, and is directly replaceable by FPGA distributed RAM.
- The FSM and valid bits stay in inst_cache.

Test Plan:
- Cold miss:
  - Stimulus: reset, then inst_ren=1, inst_addr=0x0000_0008; memory returns 0x1000_0000+word_addr with ack every cycle.
  - Response: mem_addr sequence 0x0,0x4,0x8,0xC. inst_stall=1 for 6 cycles, then inst_data=0x1000_0008 with inst_stall=0.
- Hit in filled line: after the cold miss, inst_addr=0x0, 0x4, 0xC on successive cycles → inst_stall=0 each cycle, data 0x1000_0000/0x1000_0004/0x1000_000C, mem_req stays 0.
- Conflict miss: inst_addr=0x0000_0100 (same index 0, different tag) → new 4-word fill at 0x100–0x10C; a subsequent fetch of 0x0 misses again.
- Slow memory with address change mid-fill:
  - Stimulus: ack only every 3rd cycle; change inst_addr from 0x20 to 0x40 during FILL.
  - Response: fill completes for 0x20–0x2C with mem_addr stable between acks, then a fresh fill for 0x40 starts.
- Flush during FILL: assert flush for 1 cycle mid-fill → after DONE, a fetch of the same address misses and refills; mem_req never drops mid-line.
- Reset mid-fill: assert cpu_rst after 2 acks → mem_req=0, mem_addr=0 next cycle; a fetch of a previously cached address misses.
